// File: rtl/tdp_ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of RAM port B (write-first, 1-cycle read latency).
// After reset, and on every flush, the arbiter zeroes the whole RAM before it grants any request.
module tdp_ram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic [AW-1:0]         addr_0,
    input  logic [AW-1:0]         addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  rvalid,
    output logic                  rid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  ram_en_b,
    output logic                  ram_we_b,
    output logic [AW-1:0]         ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_in_b,
    input  logic [DATA_WIDTH-1:0] ram_data_out_b
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            last_grant_q, last_grant_d;
    logic            rvalid_q, rvalid_d;
    logic            rid_q, rid_d;
    logic            gnt_0_s, gnt_1_s;

    // Grant decision: on a tie the requester that did not win last time is served.
    always_comb begin
        gnt_0_s = 1'b0;
        gnt_1_s = 1'b0;
        if (state_q == ST_SERVE) begin
            if (req_0 && req_1) begin
                if (last_grant_q) begin
                    gnt_0_s = 1'b1;
                end else begin
                    gnt_1_s = 1'b1;
                end
            end else begin
                gnt_0_s = req_0;
                gnt_1_s = req_1;
            end
        end else begin
            gnt_0_s = 1'b0;
            gnt_1_s = 1'b0;
        end
    end

    // RAM port B steering: clear sweep, granted requester, or idle.
    always_comb begin
        ram_en_b      = 1'b0;
        ram_we_b      = 1'b0;
        ram_addr_b    = '0;
        ram_data_in_b = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_en_b      = 1'b1;
                ram_we_b      = 1'b1;
                ram_addr_b    = clr_cnt_q;
                ram_data_in_b = '0;
            end
            ST_SERVE: begin
                if (gnt_0_s) begin
                    ram_en_b      = 1'b1;
                    ram_we_b      = we_0;
                    ram_addr_b    = addr_0;
                    ram_data_in_b = wdata_0;
                end else if (gnt_1_s) begin
                    ram_en_b      = 1'b1;
                    ram_we_b      = we_1;
                    ram_addr_b    = addr_1;
                    ram_data_in_b = wdata_1;
                end else begin
                    ram_en_b      = 1'b0;
                    ram_we_b      = 1'b0;
                    ram_addr_b    = '0;
                    ram_data_in_b = '0;
                end
            end
            default: begin
                ram_en_b      = 1'b0;
                ram_we_b      = 1'b0;
                ram_addr_b    = '0;
                ram_data_in_b = '0;
            end
        endcase
    end

    // Next-state logic for the FSM, clear counter, round-robin pointer and read tracking.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        rvalid_d     = (gnt_0_s && !we_0) || (gnt_1_s && !we_1);
        rid_d        = rid_q;

        if (gnt_0_s) begin
            last_grant_d = 1'b0;
        end else if (gnt_1_s) begin
            last_grant_d = 1'b1;
        end else begin
            last_grant_d = last_grant_q;
        end

        if (rvalid_d) begin
            rid_d = gnt_1_s;
        end else begin
            rid_d = rid_q;
        end

        // A flush seen while clearing is dropped so the sweep is never restarted.
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_SERVE;
                    clr_cnt_d = '0;
                end else begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            ST_SERVE: begin
                if (flush_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    state_d   = ST_SERVE;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset drops any read in flight and restarts the clear at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            rvalid_q     <= 1'b0;
            rid_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rvalid_q     <= rvalid_d;
            rid_q        <= rid_d;
        end
    end

    assign gnt_0  = gnt_0_s;
    assign gnt_1  = gnt_1_s;
    assign busy   = (state_q == ST_CLEAR);
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign rdata  = ram_data_out_b;

endmodule

// File: doc/tdp_ram_port_arbiter.md
TDP_RAM_PORT_ARBITER -- requirements
Module: tdp_ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, RAM word count; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_0 / req_1, input, 1, requester access request.
REQ-006 SHALL have ports we_0 / we_1, input, 1, request is a write.
REQ-007 SHALL have ports addr_0 / addr_1, input, AW, request address.
REQ-008 SHALL have ports wdata_0 / wdata_1, input, DATA_WIDTH, write data.
REQ-009 SHALL have ports gnt_0 / gnt_1, output, 1, combinational grant; the request is accepted this cycle.
REQ-010 SHALL have port rvalid, output, 1, read data valid.
REQ-011 SHALL have port rid, output, 1, requester index owning rdata.
REQ-012 SHALL have port rdata, output, DATA_WIDTH, read data.
REQ-013 SHALL have port flush_req, input, 1, single-cycle pulse requesting a RAM clear.
REQ-014 SHALL have port busy, output, 1, clear sequence in progress.
REQ-015 SHALL have ports ram_en_b, ram_we_b (output, 1), ram_addr_b (output, AW), ram_data_in_b (output, DATA_WIDTH), ram_data_out_b (input, DATA_WIDTH), driving write-first RAM port B with 1-cycle read latency.

Function
REQ-016 SHALL implement FSM states CLEAR and SERVE.
REQ-017 In CLEAR, SHALL drive ram_en_b=1, ram_we_b=1, ram_data_in_b=0, ram_addr_b=clr_cnt; gnt_0=gnt_1=0; busy=1.
REQ-018 clr_cnt SHALL be AW bits wide and increment by 1 per cycle in CLEAR; at clr_cnt==DEPTH-1 the FSM SHALL enter SERVE next cycle and clr_cnt SHALL return to 0.
REQ-019 A full clear SHALL take exactly DEPTH cycles.
REQ-020 In SERVE, busy SHALL be 0; a flush_req pulse SHALL enter CLEAR next cycle with clr_cnt=0. Any grant issued in that same cycle still completes.
REQ-021 flush_req asserted while in CLEAR SHALL be ignored; the clear does not restart.
REQ-022 In SERVE, a single active request SHALL be granted in the same cycle.
REQ-023 When both requests are active in SERVE, the grant SHALL go to the requester not granted most recently (round-robin).
REQ-024 last_grant SHALL update only on a grant.
REQ-025 At most one gnt SHALL be high per cycle; gnt_x SHALL never be high without req_x.
REQ-026 On grant, SHALL drive ram_en_b=1, ram_we_b=we_x, ram_addr_b=addr_x, ram_data_in_b=wdata_x.
REQ-027 With no grant, ram_en_b SHALL be 0.
REQ-028 For a granted read, rvalid SHALL be 1 exactly one cycle later, with rid=x and rdata=ram_data_out_b.
REQ-029 Granted writes SHALL produce no rvalid.
REQ-030 rvalid SHALL be 0 in all other cycles.
REQ-031 rdata SHALL be a combinational pass-through of ram_data_out_b; it is valid only while rvalid=1.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force: state=CLEAR, clr_cnt=0, last_grant=1 (so requester 0 wins the first tie), rvalid=0, rid=0.
REQ-033 After rst_n deasserts, SHALL perform a full DEPTH-cycle clear before serving any request.
REQ-034 Reset asserted mid-clear or mid-read SHALL abort the operation; no rvalid SHALL follow the aborted read.

Verification (DEPTH=8, DATA_WIDTH=32)
REQ-035 Release reset, hold req_0=1 -> busy=1 for 8 cycles with ram_addr_b 0..7 and ram_we_b=1; gnt_0 first rises in cycle 9.
REQ-036 In SERVE, req_0 write addr 3 data 0xDEADBEEF, then req_1 read addr 3 -> next cycle rvalid=1, rid=1, rdata=0xDEADBEEF.
REQ-037 req_0 and req_1 both held for 4 cycles -> grants alternate 0,1,0,1.
REQ-038 Write 0x5 at addr 2, pulse flush_req, wait for busy to fall, read addr 2 -> rdata=0.
REQ-039 Pulse flush_req in the 3rd clear cycle -> clear still ends after 8 total cycles.
REQ-040 Drop rst_n in the cycle after a read grant -> rvalid stays 0; the clear restarts at address 0.
